// File: rtl/instr_prog_sequencer_pkg.sv
// Shared definitions for the instruction program sequencer: instruction width,
// default program depth and the playback state encoding.
package ising_config;

    localparam int instr_width        = 16;
    localparam int prog_depth_default = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/instr_prog_sequencer_ram.sv
// Program store: one write port, one registered read port, PROG_DEPTH x instr_width.
module instr_prog_ram
    import ising_config::*;
#(
    parameter int PROG_DEPTH = prog_depth_default,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [instr_width-1:0] wdata,
    input  logic                   re,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [instr_width-1:0] rdata
);

    logic [instr_width-1:0] mem [PROG_DEPTH];
    logic [instr_width-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_prog_sequencer.sv
// Replays a CPU-loaded instruction program loop_count times as an AXI-Stream source.
// Optional XOR checksum of delivered words is enabled by defining INSTR_SEQ_CKSUM_EN.
module instr_prog_sequencer
    import ising_config::*;
#(
    parameter int PROG_DEPTH = prog_depth_default,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       prog_wdata,
    input  logic              prog_wvalid,
    output logic              prog_wready,
    input  logic              prog_clear,
    input  logic [15:0]       loop_count,
    input  logic              start,
    output logic [15:0]       instr_axis_tdata,
    output logic              instr_axis_tvalid,
    input  logic              instr_axis_tready,
    output logic              halt,
    output logic              busy,
    output logic [ADDR_W:0]   prog_len,
    output logic [15:0]       loops_done,
    output logic              wr_overflow,
    output logic [15:0]       prog_cksum
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(PROG_DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    seq_state_t        state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       loops_q, loops_d;
    logic [15:0]       lc_q, lc_d;
    logic              ovf_q, ovf_d;
    logic              halt_q, halt_d;
    logic              rvld_q, rvld_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [15:0]       ent0_q, ent0_d;
    logic [15:0]       ent1_q, ent1_d;

    logic [15:0]       rdata;
    logic              rd_en, wr_en, push, pop, start_ok, last_word;
    logic [ADDR_W-1:0] cur_ptr;
    logic [15:0]       cur_loops, cur_lc;

    assign prog_wready = (state_q == IDLE) && (len_q < DEPTH_L);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        loops_d = loops_q;
        lc_d    = lc_q;
        ovf_d   = ovf_q;
        rvld_d  = 1'b0;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;

        pop      = (cnt_q != 2'd0) && instr_axis_tready;
        push     = rvld_q;
        start_ok = start && !prog_clear && (state_q == IDLE || state_q == DONE);
        wr_en    = prog_wvalid && prog_wready && !prog_clear && !start;

        if (prog_wvalid && !prog_wready) ovf_d = 1'b1;
        if (wr_en) len_d = len_q + LEN_ONE;

        // Two-entry skid buffer; ent0 is the head presented on the bus.
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = rdata;
                else               ent1_d = rdata;
            end
            2'b01: ent0_d = ent1_q;
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = rdata;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = rdata;
                end
            end
            default: ;
        endcase

        // The first read is issued in the start cycle itself so tvalid rises two cycles later.
        cur_ptr   = start_ok ? '0 : ptr_q;
        cur_loops = start_ok ? 16'd0 : loops_q;
        cur_lc    = start_ok ? ((loop_count == 16'd0) ? 16'd1 : loop_count) : lc_q;
        last_word = ({1'b0, cur_ptr} == (len_q - LEN_ONE));
        rd_en     = (start_ok && len_q != '0) || (state_q == PLAY && cnt_d < 2'd2);

        if (start_ok) begin
            lc_d = cur_lc;
            if (len_q == '0) state_d = DONE;
        end

        if (rd_en) begin
            rvld_d = 1'b1;
            if (last_word) begin
                loops_d = cur_loops + 16'd1;
                ptr_d   = '0;
                state_d = (({1'b0, cur_loops} + 17'd1) < {1'b0, cur_lc}) ? PLAY : DRAIN;
            end else begin
                loops_d = cur_loops;
                ptr_d   = cur_ptr + 1'b1;
                state_d = PLAY;
            end
        end

        if (state_q == DRAIN && cnt_d == 2'd0) state_d = DONE;

        if (prog_clear) begin
            state_d = IDLE;
            len_d   = '0;
            cnt_d   = 2'd0;
            rvld_d  = 1'b0;
            rd_en   = 1'b0;
        end

        halt_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            loops_q <= '0;
            lc_q    <= 16'd1;
            ovf_q   <= 1'b0;
            halt_q  <= 1'b0;
            rvld_q  <= 1'b0;
            cnt_q   <= 2'd0;
            ent0_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            loops_q <= loops_d;
            lc_q    <= lc_d;
            ovf_q   <= ovf_d;
            halt_q  <= halt_d;
            rvld_q  <= rvld_d;
            cnt_q   <= cnt_d;
            ent0_q  <= ent0_d;
        end
    end

    always_ff @(posedge clk) begin
        ent1_q <= ent1_d;
    end

    instr_prog_ram #(
        .PROG_DEPTH (PROG_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (len_q[ADDR_W-1:0]),
        .wdata (prog_wdata),
        .re    (rd_en),
        .raddr (cur_ptr),
        .rdata (rdata)
    );

`ifdef INSTR_SEQ_CKSUM_EN
    logic [15:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (start_ok)  cksum_d = '0;
        else if (pop)  cksum_d = cksum_q ^ ent0_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cksum_q <= '0;
        else      cksum_q <= cksum_d;
    end

    assign prog_cksum = cksum_q;
`else
    assign prog_cksum = '0;
`endif

    assign instr_axis_tdata  = ent0_q;
    assign instr_axis_tvalid = (cnt_q != 2'd0);
    assign halt              = halt_q;
    assign busy              = (state_q == PLAY) || (state_q == DRAIN);
    assign prog_len          = len_q;
    assign loops_done        = loops_q;
    assign wr_overflow       = ovf_q;

endmodule

// File: tb/tb_instr_prog_sequencer.sv
// Self-checking bench for instr_prog_sequencer: scoreboard model of the expected
// instruction stream plus directed literal checks and randomized playback.
module tb_instr_prog_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   prog_wdata;
    logic          prog_wvalid;
    logic          prog_wready;
    logic          prog_clear;
    logic [15:0]   loop_count;
    logic          start;
    logic [15:0]   tdata;
    logic          tvalid;
    logic          tready;
    logic          halt;
    logic          busy;
    logic [AW:0]   prog_len;
    logic [15:0]   loops_done;
    logic          wr_overflow;
    logic [15:0]   prog_cksum;

    always #5 clk = ~clk;

    instr_prog_sequencer #(.PROG_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .prog_wdata        (prog_wdata),
        .prog_wvalid       (prog_wvalid),
        .prog_wready       (prog_wready),
        .prog_clear        (prog_clear),
        .loop_count        (loop_count),
        .start             (start),
        .instr_axis_tdata  (tdata),
        .instr_axis_tvalid (tvalid),
        .instr_axis_tready (tready),
        .halt              (halt),
        .busy              (busy),
        .prog_len          (prog_len),
        .loops_done        (loops_done),
        .wr_overflow       (wr_overflow),
        .prog_cksum        (prog_cksum)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program contents, expected word stream and coarse run state.
    int          ms;
    int          mlen;
    logic [15:0] mprog [DEPTH];
    bit          movf;
    int          mloops;
    bit          mloops_known;
    logic [15:0] exp_q[$];
    logic [15:0] mcks;
    int          age;
    bit          allready;
    bit          chk_en = 1'b0;
    bit          prev_vld, prev_rdy, prev_clr, prev_halt;
    logic [15:0] prev_data;
    int          cyc = 0;
    int          start_cyc = 0;
    int          halt_rise_cyc = 0;
    logic [15:0] beat_data[$];
    int          beat_cyc[$];

    task automatic model_reset();
        ms = M_IDLE;
        mlen = 0;
        movf = 1'b0;
        mloops = 0;
        mloops_known = 1'b1;
        exp_q.delete();
        mcks = '0;
        age = 0;
        allready = 1'b0;
        prev_vld = 1'b0;
        prev_rdy = 1'b0;
        prev_clr = 1'b0;
        prev_halt = 1'b0;
        prev_data = '0;
    endtask

    always @(negedge clk) begin
        int  n;
        bit  hs;
        cyc++;
        if (chk_en) begin
            hs = tvalid && tready;
            chk("prog_wready", prog_wready, (ms == M_IDLE) && (mlen < DEPTH));
            chk("prog_len", 32'(prog_len), mlen);
            chk("wr_overflow", wr_overflow, movf);
            chk("halt", halt, ms == M_DONE);
            chk("busy", busy, ms == M_RUN);
            if (ms != M_RUN) begin
                chk("tvalid_not_running", tvalid, 1'b0);
            end else begin
                age++;
                if (age == 1)     chk("tvalid_latency", tvalid, 1'b0);
                else if (allready) chk("tvalid_no_bubble", tvalid, 1'b1);
                if (!tready) allready = 1'b0;
            end
            if (prev_vld && !prev_rdy && !prev_clr) begin
                chk("stall_tvalid", tvalid, 1'b1);
                chk("stall_tdata", tdata, prev_data);
            end
            if (ms != M_RUN && mloops_known) chk("loops_done", loops_done, mloops);
`ifdef INSTR_SEQ_CKSUM_EN
            if (ms == M_DONE) chk("prog_cksum", prog_cksum, mcks);
`else
            chk("prog_cksum_tied", prog_cksum, 16'd0);
`endif
            if (halt && !prev_halt) halt_rise_cyc = cyc;
            if (hs) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat: got 0x%0h, expected no beat (t=%0t)", tdata, $time);
                end else begin
                    n_cmp--;
                    chk("beat_data", tdata, exp_q.pop_front());
                end
                mcks ^= tdata;
                beat_data.push_back(tdata);
                beat_cyc.push_back(cyc);
            end
            // Advance the model to what the next clock edge must produce.
            if (prog_wvalid && !((ms == M_IDLE) && (mlen < DEPTH))) movf = 1'b1;
            if (prog_clear) begin
                if (ms == M_RUN) mloops_known = 1'b0;
                ms = M_IDLE;
                mlen = 0;
                exp_q.delete();
            end else begin
                if (prog_wvalid && ms == M_IDLE && mlen < DEPTH && !start) begin
                    mprog[mlen] = prog_wdata;
                    mlen++;
                end
                if (start && ms != M_RUN) begin
                    mcks = '0;
                    start_cyc = cyc;
                    if (mlen == 0) begin
                        ms = M_DONE;
                    end else begin
                        n = (loop_count == 16'd0) ? 1 : int'(loop_count);
                        exp_q.delete();
                        for (int p = 0; p < n; p++)
                            for (int i = 0; i < mlen; i++) exp_q.push_back(mprog[i]);
                        mloops = n;
                        mloops_known = 1'b1;
                        ms = M_RUN;
                        age = 0;
                        allready = 1'b1;
                    end
                end else if (ms == M_RUN && exp_q.size() == 0) begin
                    ms = M_DONE;
                end
            end
            prev_vld = tvalid;
            prev_rdy = tready;
            prev_clr = prog_clear;
            prev_data = tdata;
            prev_halt = halt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] w);
        prog_wdata = w;
        prog_wvalid = 1'b1;
        tick();
        prog_wvalid = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] lc);
        loop_count = lc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        prog_clear = 1'b1;
        tick();
        prog_clear = 1'b0;
    endtask

    task automatic wait_halt(input bit rnd, input int maxc);
        for (int k = 0; k < maxc; k++) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (halt) break;
        end
        chk("halt_within_budget", halt, 1'b1);
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tdata"}, tdata, 16'd0);
        chk({tag, "_tvalid"}, tvalid, 1'b0);
        chk({tag, "_halt"}, halt, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_prog_len"}, 32'(prog_len), 0);
        chk({tag, "_loops_done"}, loops_done, 16'd0);
        chk({tag, "_wr_overflow"}, wr_overflow, 1'b0);
        chk({tag, "_prog_cksum"}, prog_cksum, 16'd0);
        chk({tag, "_prog_wready"}, prog_wready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] basic_exp [6];
        int base, n, ab, k;
        bit ended;
        basic_exp = '{16'h1, 16'h2, 16'h4, 16'h1, 16'h2, 16'h4};

        rst = 1'b0;
        prog_wdata = '0;
        prog_wvalid = 1'b0;
        prog_clear = 1'b0;
        loop_count = '0;
        start = 1'b0;
        tready = 1'b0;
        model_reset();
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b1;
        chk_en = 1'b1;
        tick();

        // Basic playback: three words, two passes, sink always ready.
        write_word(16'h0001);
        write_word(16'h0002);
        write_word(16'h0004);
        tready = 1'b1;
        base = beat_data.size();
        pulse_start(16'd2);
        wait_halt(1'b0, 50);
        chk("basic_beat_count", beat_data.size() - base, 6);
        if (beat_data.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) chk("basic_word", beat_data[base+i], basic_exp[i]);
            chk("basic_first_latency", beat_cyc[base] - start_cyc, 2);
            chk("basic_back_to_back", beat_cyc[base+5] - beat_cyc[base], 5);
            chk("basic_halt_after_last", halt_rise_cyc - beat_cyc[base+5], 1);
        end
        chk("basic_loops_done", loops_done, 16'd2);
        chk("basic_halt", halt, 1'b1);
`ifdef INSTR_SEQ_CKSUM_EN
        chk("basic_cksum", prog_cksum, 16'h0000);
`endif

        // Replay from DONE under random backpressure.
        pulse_start(16'd3);
        wait_halt(1'b1, 200);
        chk("replay_loops_done", loops_done, 16'd3);

        // Empty program: straight to DONE.
        pulse_clear();
        chk("clear_halt", halt, 1'b0);
        pulse_start(16'd4);
        chk("empty_halt", halt, 1'b1);
        chk("empty_busy", busy, 1'b0);
        tick();

        // Full memory and overflow, then play the full program.
        pulse_clear();
        for (int i = 0; i < DEPTH + 1; i++) write_word(16'($urandom));
        chk("full_prog_len", 32'(prog_len), DEPTH);
        chk("full_wready", prog_wready, 1'b0);
        chk("full_overflow", wr_overflow, 1'b1);
        pulse_start(16'd1);
        wait_halt(1'b1, 200);

        // Abort mid-PLAY with the sink stalled.
        pulse_clear();
        for (int i = 0; i < 5; i++) write_word(16'h0100 + 16'(i));
        tready = 1'b0;
        pulse_start(16'd3);
        tick();
        tick();
        tick();
        chk("abort_tvalid_before", tvalid, 1'b1);
        pulse_clear();
        chk("abort_tvalid", tvalid, 1'b0);
        chk("abort_prog_len", 32'(prog_len), 0);
        chk("abort_halt", halt, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_wready", prog_wready, 1'b1);
        chk("abort_loops_done", loops_done, 16'd0);
        tick();

        // Reset mid-PLAY, then load and play again.
        for (int i = 0; i < 4; i++) write_word(16'h0A00 + 16'(i));
        tready = 1'b1;
        pulse_start(16'd2);
        tick();
        tick();
        chk_en = 1'b0;
        rst = 1'b0;
        #2;
        check_reset_values("midreset");
        tick();
        rst = 1'b1;
        model_reset();
        chk_en = 1'b1;
        tick();
        write_word(16'h1234);
        write_word(16'h5678);
        write_word(16'h9ABC);
        pulse_start(16'd2);
        wait_halt(1'b1, 200);
        chk("post_reset_loops_done", loops_done, 16'd2);

        // Randomized programs, loop counts, backpressure, stray starts/writes and aborts.
        for (int it = 0; it < 30; it++) begin
            pulse_clear();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) write_word(16'($urandom));
            pulse_start(16'($urandom_range(0, 3)));
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
            ended = 1'b0;
            for (k = 0; k < 400; k++) begin
                tready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 15) == 0);
                loop_count = 16'($urandom_range(0, 3));
                prog_wvalid = ($urandom_range(0, 15) == 0);
                prog_wdata = 16'($urandom);
                prog_clear = (ab != 0 && k == ab);
                tick();
                start = 1'b0;
                prog_wvalid = 1'b0;
                if (prog_clear) begin
                    prog_clear = 1'b0;
                    ended = 1'b1;
                    break;
                end
                if (halt) begin
                    ended = 1'b1;
                    break;
                end
            end
            chk("rand_run_terminated", ended, 1'b1);
            if (halt && $urandom_range(0, 1) == 1) begin
                pulse_start(16'($urandom_range(0, 2)));
                wait_halt(1'b1, 200);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
